// File: rtl/bram_dp_clear_if.sv
// Port bundle for bram_dp_clear: port A read/write with lane enables, port B read-only.
// The master drives requests; the slave (the RAM) returns read data and valid strobes.
interface bram_dp_clear_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

    logic                  a_en;
    logic [NUM_LANES-1:0]  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_din;
    logic [DATA_WIDTH-1:0] a_dout;
    logic                  a_valid;
    logic                  b_en;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_dout;
    logic                  b_valid;

    modport master (
        output a_en, a_we, a_addr, a_din, b_en, b_addr,
        input  a_dout, a_valid, b_dout, b_valid
    );

    modport slave (
        input  a_en, a_we, a_addr, a_din, b_en, b_addr,
        output a_dout, a_valid, b_dout, b_valid
    );
endinterface

// File: rtl/bram_dp_clear.sv
// Single-clock dual-port RAM with lane write enables, selectable read-during-write,
// optional output register, read-valid strobes and a whole-array clear sequencer.
//
// state | meaning
// IDLE  | normal operation, both ports serve requests
// CLEAR | writing CLEAR_VALUE to clr_addr each cycle, accesses ignored
module bram_dp_clear #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    LANE_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 11,
    parameter int                    OUT_REG        = 0,
    parameter int                    RDW_MODE       = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    output logic            busy_o,
    bram_dp_clear_if.slave  mem_if
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  a_acc, b_acc, clr_wr;
    logic [DATA_WIDTH-1:0] a_old, a_merged, a_rd, b_rd;

    logic                  a_valid_s1_q, b_valid_s1_q;
    logic [DATA_WIDTH-1:0] a_dout_s1_q, b_dout_s1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (clear_i) state_d = CLEAR;
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                if (clr_addr_q == '1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // clear wins over a same-cycle access, and nothing is accepted while reset is held
    always_comb begin
        busy_o = (state_q == CLEAR);
        clr_wr = (state_q == CLEAR) && !reset;
        a_acc  = (state_q == IDLE) && !reset && !clear_i && mem_if.a_en;
        b_acc  = (state_q == IDLE) && !reset && !clear_i && mem_if.b_en;
    end

    always_comb begin
        a_old    = mem_q[mem_if.a_addr];
        b_rd     = mem_q[mem_if.b_addr];
        a_merged = a_old;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mem_if.a_we[i])
                a_merged[i*LANE_WIDTH +: LANE_WIDTH] = mem_if.a_din[i*LANE_WIDTH +: LANE_WIDTH];
        end
        a_rd = (RDW_MODE != 0) ? a_merged : a_old;
    end

    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem_q[clr_addr_q] <= CLEAR_VALUE;
        end else if (a_acc) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (mem_if.a_we[i])
                    mem_q[mem_if.a_addr][i*LANE_WIDTH +: LANE_WIDTH] <=
                        mem_if.a_din[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // port B samples the array before this edge's port A write lands: always old data
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_s1_q <= 1'b0;
            a_dout_s1_q  <= '0;
            b_valid_s1_q <= 1'b0;
            b_dout_s1_q  <= '0;
        end else begin
            a_valid_s1_q <= a_acc;
            b_valid_s1_q <= b_acc;
            if (a_acc) a_dout_s1_q <= a_rd;
            if (b_acc) b_dout_s1_q <= b_rd;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  a_valid_s2_q, b_valid_s2_q;
            logic [DATA_WIDTH-1:0] a_dout_s2_q, b_dout_s2_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_valid_s2_q <= 1'b0;
                    a_dout_s2_q  <= '0;
                    b_valid_s2_q <= 1'b0;
                    b_dout_s2_q  <= '0;
                end else begin
                    a_valid_s2_q <= a_valid_s1_q;
                    b_valid_s2_q <= b_valid_s1_q;
                    if (a_valid_s1_q) a_dout_s2_q <= a_dout_s1_q;
                    if (b_valid_s1_q) b_dout_s2_q <= b_dout_s1_q;
                end
            end

            assign mem_if.a_valid = a_valid_s2_q;
            assign mem_if.a_dout  = a_dout_s2_q;
            assign mem_if.b_valid = b_valid_s2_q;
            assign mem_if.b_dout  = b_dout_s2_q;
        end else begin : g_no_out_reg
            assign mem_if.a_valid = a_valid_s1_q;
            assign mem_if.a_dout  = a_dout_s1_q;
            assign mem_if.b_valid = b_valid_s1_q;
            assign mem_if.b_dout  = b_dout_s1_q;
        end
    endgenerate
endmodule

// File: tb/tb_bram_dp_clear.sv
// Bench for bram_dp_clear: two instances (no out reg / read-first, out reg / write-first)
// share one stimulus; a queue scoreboard checks every valid strobe, its cycle and data.
module tb_bram_dp_clear;
    localparam int DW = 16;
    localparam int LW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic busy0, busy1;

    logic          a_en = 1'b0;
    logic [1:0]    a_we = '0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_din = '0;
    logic          b_en = 1'b0;
    logic [AW-1:0] b_addr = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic rst_q = 1'b1;
    int left = DEPTH;

    logic [DW-1:0] model [DEPTH];
    sb_t           sbq [4][$];
    logic [DW-1:0] last [4];
    string         pn [4] = '{"d0.a", "d0.b", "d1.a", "d1.b"};

    bram_dp_clear_if #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .ADDR_WIDTH(AW)) if0 ();
    bram_dp_clear_if #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .ADDR_WIDTH(AW)) if1 ();

    assign if0.a_en = a_en;   assign if1.a_en = a_en;
    assign if0.a_we = a_we;   assign if1.a_we = a_we;
    assign if0.a_addr = a_addr; assign if1.a_addr = a_addr;
    assign if0.a_din = a_din; assign if1.a_din = a_din;
    assign if0.b_en = b_en;   assign if1.b_en = b_en;
    assign if0.b_addr = b_addr; assign if1.b_addr = b_addr;

    bram_dp_clear #(
        .DATA_WIDTH(DW), .LANE_WIDTH(LW), .ADDR_WIDTH(AW),
        .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h0000)
    ) d0 (
        .clk(clk), .reset(reset), .clear_i(clear), .busy_o(busy0), .mem_if(if0)
    );

    bram_dp_clear #(
        .DATA_WIDTH(DW), .LANE_WIDTH(LW), .ADDR_WIDTH(AW),
        .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h0000)
    ) d1 (
        .clk(clk), .reset(reset), .clear_i(clear), .busy_o(busy1), .mem_if(if1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    logic [3:0]    vv;
    logic [DW-1:0] dd [4];
    logic          exp_v;
    logic [DW-1:0] exp_d;

    always @(negedge clk) begin
        if (cyc > 0) begin
            vv    = {if1.b_valid, if1.a_valid, if0.b_valid, if0.a_valid};
            dd[0] = if0.a_dout;
            dd[1] = if0.b_dout;
            dd[2] = if1.a_dout;
            dd[3] = if1.b_dout;
            vectors++;
            assert ({busy1, busy0} === {2{left != 0}}) else begin
                miscompares++;
                $error("FAIL busy cyc %0d: got %b want %b", cyc, {busy1, busy0}, {2{left != 0}});
            end
            for (int p = 0; p < 4; p++) begin
                if (rst_q) last[p] = '0;
                exp_v = !rst_q && (sbq[p].size() > 0) && (sbq[p][0].cyc == cyc);
                exp_d = exp_v ? sbq[p][0].data : last[p];
                vectors++;
                assert (vv[p] === exp_v) else begin
                    miscompares++;
                    $error("FAIL valid %s cyc %0d: got %b want %b", pn[p], cyc, vv[p], exp_v);
                end
                vectors++;
                assert (dd[p] === exp_d) else begin
                    miscompares++;
                    $error("FAIL dout %s cyc %0d: got %h want %h", pn[p], cyc, dd[p], exp_d);
                end
                if (exp_v) begin
                    last[p] = exp_d;
                    void'(sbq[p].pop_front());
                end
            end
        end
    end

    // One clock of stimulus; expectations are queued before the edge, busy model updated at it.
    task automatic step(input logic ae, input logic [1:0] we, input logic [AW-1:0] aa,
                        input logic [DW-1:0] ad, input logic be, input logic [AW-1:0] ba,
                        input logic clr);
        logic          acc;
        logic [DW-1:0] old, merged;
        a_en = ae; a_we = we; a_addr = aa; a_din = ad;
        b_en = be; b_addr = ba; clear = clr;
        acc = (left == 0) && !clr;
        if (acc && be) begin
            sbq[1].push_back('{cyc + 1, model[ba]});
            sbq[3].push_back('{cyc + 2, model[ba]});
        end
        if (acc && ae) begin
            old = model[aa];
            merged = old;
            for (int l = 0; l < 2; l++)
                if (we[l]) merged[l*LW +: LW] = ad[l*LW +: LW];
            sbq[0].push_back('{cyc + 1, old});
            sbq[2].push_back('{cyc + 2, merged});
            model[aa] = merged;
        end
        if (left == 0 && clr)
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(posedge clk);
        if (left > 0) left--;
        else if (clr) left = DEPTH;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] aa, input logic [DW-1:0] ad, input logic [1:0] we);
        step(1'b1, we, aa, ad, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] aa, input logic [AW-1:0] ba);
        step(1'b1, 2'b00, aa, 16'hDEAD, 1'b1, ba, 1'b0);
    endtask

    task automatic do_reset(input int n);
        a_en = 1'b0; b_en = 1'b0; a_we = '0; clear = 1'b0;
        reset = 1'b1;
        for (int p = 0; p < 4; p++)
            while (sbq[p].size() > 0 && sbq[p][$].cyc > cyc) void'(sbq[p].pop_back());
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            left = DEPTH;
            #1;
        end
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int p = 0; p < 4; p++) last[p] = '0;

        // power-up reset and the automatic clear that follows it
        do_reset(3);
        idle(DEPTH + 1);

        // lane write enables
        wr(4'd3, 16'hBEEF, 2'b11);
        wr(4'd3, 16'h1234, 2'b10);
        rd(4'd0, 4'd3);
        idle(2);

        // read-during-write on address 5
        wr(4'd5, 16'h1111, 2'b11);
        step(1'b1, 2'b11, 4'd5, 16'h2222, 1'b1, 4'd5, 1'b0);
        rd(4'd5, 4'd5);
        idle(2);

        // back-to-back reads over the whole array
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 16'h0100 + DW'(i * 3), 2'b11);
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), AW'(DEPTH - 1 - i));
        idle(3);

        // clear with accesses during busy and a second clear mid-sequence
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 16'hAAAA, 2'b11);
        step(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 2'b11, AW'(i), 16'h5A5A, 1'b1, AW'(i), i == 5);
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), AW'(i));
        idle(3);

        // clear collides with a write to address 2
        wr(4'd2, 16'h7777, 2'b11);
        step(1'b1, 2'b11, 4'd2, 16'h5555, 1'b0, '0, 1'b1);
        idle(DEPTH);
        rd(4'd2, 4'd2);
        idle(3);

        // reset with reads in flight flushes the output stage
        wr(4'd9, 16'hC3C3, 2'b11);
        rd(4'd9, 4'd9);
        do_reset(2);
        idle(DEPTH + 1);

        // reset in the 7th cycle of a clear restarts it from address 0
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 16'hAAAA, 2'b11);
        step(1'b0, 2'b00, '0, '0, 1'b0, '0, 1'b1);
        idle(6);
        do_reset(2);
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), AW'(i));
        idle(4);

        vectors++;
        assert ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) === 0) else begin
            miscompares++;
            $error("FAIL drain: got %0d pending want 0",
                   sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bram_dp_clear.md
# bram_dp_clear

Parametrised single-clock dual-port RAM: port A read/write with per-lane write enables, port B read-only. It adds selectable read-during-write behaviour, an optional output pipeline register, read-valid strobes and a hardware clear sequencer that zeroes the whole array. It serves as the generic buffer RAM for the firmware data paths, replacing fixed 2k×8 instances.

## Interface
- DATA_WIDTH, 8: word width; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8: bits per write-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- ADDR_WIDTH, 11: depth = 2^ADDR_WIDTH words.
- OUT_REG, 0: 1 adds one output register stage to both ports.
- RDW_MODE, 0: port A read-during-write; 0 = read-first (old data), 1 = write-first (new merged word).
- CLEAR_ON_RESET, 1: 1 runs a full clear after reset.
- CLEAR_VALUE, 0: DATA_WIDTH value written by the clear sequencer.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  request a full-array clear; sampled when idle.
- busy  out  1  high while a clear is in progress.
- a_en  in  1  port A access request.
- a_we  in  NUM_LANES  per-lane write enables, qualified by a_en.
- a_addr  in  ADDR_WIDTH  port A address.
- a_din  in  DATA_WIDTH  port A write data.
- a_dout  out  DATA_WIDTH  port A read data.
- a_valid  out  1  one-cycle strobe, a_dout holds the read for a request.
- b_en  in  1  port B read request.
- b_addr  in  ADDR_WIDTH  port B address.
- b_dout  out  DATA_WIDTH  port B read data.
- b_valid  out  1  one-cycle strobe for b_dout.

## Operation
- FSM states: IDLE, CLEAR.
  - reset: state <= CLEAR if CLEAR_ON_RESET, else IDLE; clr_addr <= 0.
  - IDLE -> CLEAR when clear = 1.
  - CLEAR -> IDLE after the write to address 2^ADDR_WIDTH-1.
- busy = (state == CLEAR). It is combinational from state, so it is high during reset when CLEAR_ON_RESET = 1.
- CLEAR: each cycle with reset low writes CLEAR_VALUE to clr_addr, then increments clr_addr.
  - In CLEAR, a_en and b_en are ignored: no write, no valid, dout holds.
  - clear asserted while busy is ignored; the sequence does not restart.
- IDLE, port A, a_en = 1:
  - Every lane i with a_we[i] = 1 is written with a_din lane i. Other lanes are unchanged.
  - A read of a_addr is always issued. A write also produces a_valid.
  - RDW_MODE = 0: a_dout returns the pre-write word. RDW_MODE = 1: a_dout returns the merged post-write word.
- a_en = 0: no write regardless of a_we.
- IDLE, port B, b_en = 1: reads b_addr.
  - If port A writes the same address in the same cycle, b_dout returns old data regardless of RDW_MODE.
  - The next b read of that address returns new data.
- clear and an access in the same IDLE cycle: clear wins, the access is dropped, no valid.
- Memory contents are not altered by reset itself, only by the clear sequence.
- Simulation initial contents: all CLEAR_VALUE.

## Timing
- Reset values: a_dout = 0, b_dout = 0, a_valid = 0, b_valid = 0, all pipeline registers 0. busy is per the FSM rule above.
- Read latency with OUT_REG = 0: request sampled at edge N gives dout and valid at edge N (visible in cycle N..N+1).
- Read latency with OUT_REG = 1: data and valid appear one edge later.
- The valid strobe lasts exactly one cycle per request. Back-to-back requests give back-to-back valids; full throughput is one access per port per cycle.
- dout holds its last value when no valid is produced.
- Clear duration: clear sampled at edge N, writes occur at edges N+1 … N+2^ADDR_WIDTH, and busy falls after edge N+2^ADDR_WIDTH.
- clr_addr wraps from 2^ADDR_WIDTH-1 to 0 together with the IDLE transition.
- Reset mid-clear: the sequence aborts, and restarts from address 0 if CLEAR_ON_RESET = 1. Reset in flight also flushes the OUT_REG stage, so no valid is emitted.

## Test plan
Bench configuration: DATA_WIDTH = 16, LANE_WIDTH = 8, ADDR_WIDTH = 4.
- Byte-enable write: after reset-clear, write 0xBEEF to addr 3 (a_we = 11), then 0x12xx with a_we = 10. Port B read of addr 3 -> 0x12EF, b_valid for 1 cycle.
- Read-during-write with addr 5 = 0x1111, then a_en with a_we = 11, a_din = 0x2222, plus b_en on addr 5 in the same cycle:
  - RDW_MODE = 0 -> a_dout = 0x1111.
  - RDW_MODE = 1 -> a_dout = 0x2222.
  - b_dout = 0x1111 in both modes.
- Latency: OUT_REG = 0 and OUT_REG = 1, reads of addresses 0..15 back-to-back. Valid follows each en by 1 and 2 edges respectively, with the data in order.
- Clear: fill all 16 words with 0xAAAA, pulse clear.
  - busy stays high for exactly 16 cycles.
  - Accesses during busy produce no valid.
  - A second clear mid-sequence does not extend busy.
  - Afterwards all words read CLEAR_VALUE.
- clear and an a_en write to addr 2 in the same cycle: the write is dropped and addr 2 reads CLEAR_VALUE.
- Reset asserted at the 7th cycle of a clear (CLEAR_ON_RESET = 1): all outputs 0, then a new 16-cycle busy window, and all words read 0.
